// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int GRANT_W       = $clog2(NUM_REQ_DEF);
  localparam int BURST_W       = $clog2(MAX_BURST_DEF) + 1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority pick: first valid requester at or after the pointer, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic               any_req_o,
  output logic [GW-1:0]      pick_id_o
);

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    any_req_o = 1'b0;
    pick_id_o = rr_ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        any_req_o = 1'b1;
        pick_id_o = GW'((int'(rr_ptr_i) + k) % NUM_REQ);
      end else begin
        any_req_o = any_req_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a per-grant burst limit and a transmit-acceptance timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int WORD_WIDTH  = 8,
  parameter int MAX_BURST   = MAX_BURST_DEF,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [WORD_WIDTH-1:0]         tx_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          tx_timeout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  arb_state_t             state_q, state_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]          ack_cnt_q, ack_cnt_d;
  logic                   last_q, last_d;
  logic [WORD_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   busy_q, busy_d;
  logic                   tx_timeout_q, tx_timeout_d;

  logic                   any_req_s;
  logic [GW-1:0]          pick_id_s;
  logic [GW-1:0]          next_ptr_s;
  logic                   lane_valid_s;
  logic                   lane_last_s;
  logic [WORD_WIDTH-1:0]  lane_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_req_o   (any_req_s),
    .pick_id_o   (pick_id_s)
  );

  assign lane_valid_s = req_valid[grant_id_q];
  assign lane_last_s  = req_last[grant_id_q];
  assign lane_data_s  = req_data[grant_id_q*WORD_WIDTH +: WORD_WIDTH];
  assign next_ptr_s   = (grant_id_q == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : grant_id_q + GW'(1);

  // Next-state and registered-output decode for the grant/transmit sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    burst_cnt_d  = burst_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    req_ready_d  = {NUM_REQ{1'b0}};
    tx_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_id_d  = pick_id_s;
          burst_cnt_d = {BW{1'b0}};
          state_d     = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (lane_valid_s && tx_ready) begin
          tx_start_d  = 1'b1;
          req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
          tx_data_d   = lane_data_s;
          last_d      = lane_last_s;
          ack_cnt_d   = {AW{1'b0}};
          state_d     = ST_WAIT_ACK;
        end else if (!lane_valid_s) begin
          rr_ptr_d = next_ptr_s;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_WAIT_ACK: begin
        // A word the transmitter never accepts is dropped, not retried.
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
          tx_timeout_d = 1'b1;
          rr_ptr_d     = next_ptr_s;
          state_d      = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q || (burst_cnt_q == BW'(MAX_BURST - 1))) begin
            rr_ptr_d = next_ptr_s;
            state_d  = ST_IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
            state_d     = ST_GRANT;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= {GW{1'b0}};
      grant_id_q   <= {GW{1'b0}};
      burst_cnt_q  <= {BW{1'b0}};
      ack_cnt_q    <= {AW{1'b0}};
      last_q       <= 1'b0;
      tx_data_q    <= {WORD_WIDTH{1'b0}};
      tx_start_q   <= 1'b0;
      req_ready_q  <= {NUM_REQ{1'b0}};
      busy_q       <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      burst_cnt_q  <= burst_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: requester queues, a simple
// transmitter model and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int WW = 8;
  localparam int MB = 2;
  localparam int AT = 8;
  localparam int GW = 2;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR*WW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              tx_ready = 1'b1;
  logic              tx_start;
  logic [WW-1:0]     tx_data;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              tx_timeout;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .WORD_WIDTH(WW), .MAX_BURST(MB), .ACK_TIMEOUT(AT)
  ) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id),
    .busy(busy), .tx_timeout(tx_timeout)
  );

  typedef struct packed { logic [WW-1:0] data; logic last; } word_t;
  typedef struct packed { logic [GW-1:0] id; logic [WW-1:0] data; } exp_t;

  word_t rq [NR][$];
  word_t mq [NR][$];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    start_log [$];
  int    fair_ref [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int    checks = 0;
  int    errors = 0;
  int    model_ptr = 0;
  bit    auto_drive = 1'b0;
  bit    expect_to = 1'b0;
  int    tx_mode = 0;   // 0 normal, 1 never accepts, 2 held busy
  bit    tx_act = 1'b0;
  int    pre_cnt = 0;
  int    low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Transmitter model: accepts a start after a short delay, busy for a random time.
  always @(posedge clock) begin
    if (tx_mode == 2) tx_ready <= 1'b0;
    else if (tx_mode == 1) tx_ready <= 1'b1;
    else if (tx_act) begin
      if (pre_cnt > 0) pre_cnt <= pre_cnt - 1;
      else if (tx_ready) tx_ready <= 1'b0;
      else if (low_cnt > 0) low_cnt <= low_cnt - 1;
      else begin
        tx_ready <= 1'b1;
        tx_act   <= 1'b0;
      end
    end else if (tx_start && tx_ready) begin
      tx_act  <= 1'b1;
      pre_cnt <= int'($urandom_range(0, 3));
      low_cnt <= int'($urandom_range(0, 4));
    end else tx_ready <= 1'b1;
  end

  // Monitor: every transmit start is matched against the scoreboard queue.
  always @(negedge clock) begin
    if (!rst) begin
      if (tx_start) begin
        start_log.push_back(int'(grant_id));
        if (exp_q.size() == 0) begin
          check("unexpected_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
          check("grant_id", {30'd0, grant_id}, {30'd0, mon_e.id});
          check("req_ready", {28'd0, req_ready}, 32'd1 << mon_e.id);
        end
      end else if (req_ready != 4'd0) begin
        check("ready_without_start", {28'd0, req_ready}, 32'd0);
      end
      if (tx_timeout) check("timeout_allowed", {31'd0, expect_to}, 32'd1);
    end
  end

  task automatic tick();
    word_t w;
    @(negedge clock);
    if (auto_drive) begin
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && rq[i].size() > 0) w = rq[i].pop_front();
        req_valid[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          req_data[i*WW +: WW] = rq[i][0].data;
          req_last[i]          = rq[i][0].last;
        end else begin
          req_data[i*WW +: WW] = 8'h00;
          req_last[i]          = 1'b0;
        end
      end
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += rq[i].size();
    return n;
  endfunction

  // Reference: whole bursts of up to MB words (or to a last word), then rotate.
  task automatic build_expect();
    int g;
    bit more;
    word_t w;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    more = 1'b1;
    while (more) begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && mq[(model_ptr + k) % NR].size() > 0) g = (model_ptr + k) % NR;
      if (g < 0) more = 1'b0;
      else begin
        for (int b = 0; b < MB; b++) begin
          if (mq[g].size() == 0) break;
          w = mq[g].pop_front();
          exp_q.push_back('{id: GW'(g), data: w.data});
          if (w.last) break;
        end
        model_ptr = (g + 1) % NR;
      end
    end
  endtask

  task automatic push_packet(input int r, input int len);
    for (int j = 0; j < len; j++)
      rq[r].push_back('{data: 8'($urandom), last: (j == len - 1)});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(busy == 1'b0 && exp_q.size() == 0 && pending() == 0 && tx_ready && !tx_act) && n < 3000);
    check({name, "_done_in_time"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    check({name, "_scoreboard_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = 4'd0;
    req_data  = 32'd0;
    req_last  = 4'd0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_tx_timeout", {31'd0, tx_timeout}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    auto_drive = 1'b1;

    // Single request from requester 2 with two-cycle start latency.
    rq[2].push_back('{data: 8'hA5, last: 1'b1});
    build_expect();
    tick();
    n = 0;
    while (!tx_start && n < 20) begin tick(); n++; end
    check("single_latency", n, 32'd2);
    wait_idle("single");

    // Burst cut by last, with other requesters pending.
    rq[1].push_back('{data: 8'h11, last: 1'b0});
    rq[1].push_back('{data: 8'h12, last: 1'b1});
    rq[1].push_back('{data: 8'h13, last: 1'b1});
    rq[2].push_back('{data: 8'h21, last: 1'b1});
    rq[3].push_back('{data: 8'h31, last: 1'b1});
    build_expect();
    wait_idle("burst_last");

    // Acceptance timeout: transmitter never drops tx_ready.
    tx_mode = 1;
    expect_to = 1'b1;
    rq[2].push_back('{data: 8'h5A, last: 1'b1});
    build_expect();
    tick();
    n = 0;
    while (!tx_start && n < 30) begin tick(); n++; end
    check("timeout_start_seen", {31'd0, tx_start}, 32'd1);
    n = 0;
    while (!tx_timeout && n < 30) begin tick(); n++; end
    check("timeout_delay", n, AT);
    check("timeout_idle", {31'd0, busy}, 32'd0);
    tick();
    expect_to = 1'b0;
    repeat (15) tick();
    tx_mode = 0;
    wait_idle("timeout");

    // Abandon: requester 0 drops valid while the transmitter is busy.
    auto_drive = 1'b0;
    tx_mode = 2;
    repeat (2) tick();
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    req_last  = 4'b0001;
    repeat (2) tick();
    check("abandon_holding", {31'd0, busy}, 32'd1);
    req_valid = 4'b0000;
    tick();
    check("abandon_idle", {31'd0, busy}, 32'd0);
    check("abandon_grant", {30'd0, grant_id}, 32'd0);
    repeat (5) tick();
    model_ptr = 1;
    tx_mode = 0;
    auto_drive = 1'b1;
    wait_idle("abandon");

    // Randomized traffic rounds.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++)
        for (int p = int'($urandom_range(0, 3)); p > 0; p--)
          push_packet(i, int'($urandom_range(1, 4)));
      build_expect();
      wait_idle("random");
    end

    // Reset while a word is in flight.
    for (int i = 0; i < NR; i++) push_packet(i, 3);
    build_expect();
    n = 0;
    while (!tx_start && n < 50) begin tick(); n++; end
    check("mid_reset_start_seen", {31'd0, tx_start}, 32'd1);
    n = 0;
    while (tx_ready && n < 20) begin tick(); n++; end
    check("mid_reset_tx_busy", {31'd0, tx_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("mid_reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_reset_grant", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_ptr = 0;
    build_expect();
    wait_idle("mid_reset");

    // Fairness from a fresh reset: all requesters continuously valid.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_ptr = 0;
    start_log.delete();
    for (int i = 0; i < NR; i++) push_packet(i, 6);
    build_expect();
    wait_idle("fairness");
    check("fair_log_len", (start_log.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 9 && k < start_log.size(); k++)
      check("fair_order", start_log[k], fair_ref[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
